test_sequencer: RTL and testbench
=================================

// Module: test_sequencer
// PURPOSE
//  Top-level per-test FSM of the memory checker. Sequences address_block via test_start_o/next_addr_en_o.
//  Issues Avalon-MM write/read transactions per generated address and checks read data against an
//  address-derived pattern. Counts errors and reports busy/done to the CSR block.
// PARAMETERS
//  ADDR_W    rtl_settings_pkg  memory word-address width (shared with address_block)
//  DATA_W    32                Avalon data width; multiple of 8
//  TMO_W     10                readdatavalid timeout counter width (timeout = 2**TMO_W - 1 cycles)
// PORTS
//  clk_i                 in   1                        clock
//  rst_i                 in   1                        async reset, active-high
//  test_start_i          in   1                        1-cycle start pulse from CSR block
//  test_param_i          in   [CSR_SET_ADDR:CSR_TEST_PARAM][31:0]  CSR test parameters
//  test_start_o          out  1                        start pulse to address_block
//  next_addr_en_o        out  1                        advance pulse to address_block
//  addr_i                in   ADDR_W                   next_addr_o of address_block
//  amm_address_o         out  ADDR_W                   Avalon address
//  amm_write_o           out  1                        Avalon write
//  amm_read_o            out  1                        Avalon read
//  amm_writedata_o       out  DATA_W                   Avalon write data
//  amm_waitrequest_i     in   1                        Avalon waitrequest
//  amm_readdatavalid_i   in   1                        Avalon read data valid
//  amm_readdata_i        in   DATA_W                   Avalon read data
//  busy_o                out  1                        test running
//  done_o                out  1                        test finished; held until next start
//  err_cnt_o             out  32                       mismatch + timeout count, saturating
//  first_err_addr_o      out  ADDR_W                   address of first error
//  timeout_o             out  1                        sticky readdatavalid timeout flag
// BEHAVIOUR
//  - CSR_TEST_PARAM fields: [10:0] word count N-1; [13:11] addr mode (address_block); [15:14] test_mode;
//    [23:16] pattern byte P. test_mode: 0 WR_ONLY, 1 RD_ONLY, 2 WR_RD (write then read-back per address), 3 = 0.
//  - Expected/write data = {DATA_W/8{P}} ^ zero-extended addr. Word count is sampled at start.
//  - Reset: all outputs 0; FSM in IDLE.
//  - FSM states: IDLE, LOAD, WR, RD, RD_WAIT, NEXT, DONE.
//    IDLE: on test_start_i, assert test_start_o (same cycle, combinational from state+input).
//      Clear err_cnt_o, first_err_addr_o, timeout_o, done_o. Load remaining=N-1. Go to LOAD.
//    LOAD: 1 cycle while addr_i settles. Then go to WR (mode 0/2) or RD (mode 1).
//    WR: amm_write_o=1, address=addr_i, writedata=pattern. Hold while waitrequest.
//      On accept: go to RD (mode 2) or NEXT.
//    RD: amm_read_o=1. Hold while waitrequest. On accept: clear timeout counter, go to RD_WAIT.
//    RD_WAIT: on readdatavalid, compare; if mismatch, count an error; go to NEXT.
//      If the counter reaches 2**TMO_W-1 first: set timeout_o, count an error, go to NEXT.
//    NEXT: if remaining==0, go to DONE. Else pulse next_addr_en_o (1 cycle), decrement remaining, go to LOAD.
//    DONE: done_o<=1, busy_o<=0, go to IDLE.
//  - busy_o=1 in every state except IDLE. The Avalon read and write strobes are never asserted
//    together, and at most one read is outstanding.
//  - Error: err_cnt_o += 1, saturating at 32'hFFFF_FFFF. first_err_addr_o is captured only when err_cnt_o==0.
//  - A readdatavalid outside RD_WAIT is ignored; it is not an error.
//  - test_start_i while busy_o=1 is ignored. test_param_i must be stable while busy.
//  - Amm outputs are registered. Address/data are held constant while waitrequest=1.
//  - Async reset mid-test aborts immediately: strobes drop, FSM returns to IDLE, counters clear.
// STRUCTURE
//  - rtl_settings_pkg additions: test_mode_t enum (WR_ONLY, RD_ONLY, WR_RD);
//    field constants CNT_MSB/LSB, TMODE_MSB/LSB, PAT_MSB/LSB.
//  - FSM state enum is local to this module. No sub-module: address_block is instantiated by the
//    parent next to this block.
// TESTING
//  1. WR_ONLY, INC_ADDR, set_addr=0x10, N-1=3, P=0xA5, waitrequest=0 -> 4 writes to 0x10..0x13,
//     wdata 0xA5A5A5B5..; done_o=1; err=0.
//  2. WR_RD, FIX_ADDR 0x20, N-1=1, model memory ideal, readdatavalid latency 3 -> 2 write/read pairs;
//     err_cnt_o=0; busy_o drops when done_o rises.
//  3. RD_ONLY, INC from 0, N-1=7, memory corrupts addr 5 -> err_cnt_o=1, first_err_addr_o=5.
//  4. RD_ONLY, slave never returns readdatavalid, TMO_W=4, N-1=1 -> timeout_o=1, err_cnt_o=2,
//     done_o=1 after about 2*16 cycles.
//  5. Random waitrequest (50%) in WR_RD, RUN_1_ADDR, N-1=15 -> address/data stable under waitrequest;
//     err=0; exactly 16 next_addr_en_o-separated pairs.
//  6. Reset asserted in RD_WAIT; second test_start_i while busy -> outputs 0 immediately; ignored start
//     leaves the running count unchanged.

Source files
------------

// File: rtl/rtl_settings_pkg.sv
// Shared settings for the memory checker: address width, CSR layout and the
// test_param field positions decoded by test_sequencer and address_block.
package rtl_settings_pkg;

  localparam int ADDR_W = 16;

  localparam int CSR_TEST_PARAM = 0;
  localparam int CSR_SET_ADDR   = 1;

  localparam int CNT_LSB   = 0;
  localparam int CNT_MSB   = 10;
  localparam int AMODE_LSB = 11;
  localparam int AMODE_MSB = 13;
  localparam int TMODE_LSB = 14;
  localparam int TMODE_MSB = 15;
  localparam int PAT_LSB   = 16;
  localparam int PAT_MSB   = 23;

  typedef enum logic [1:0] {
    WR_ONLY = 2'd0,
    RD_ONLY = 2'd1,
    WR_RD   = 2'd2
  } test_mode_t;

  typedef enum logic [2:0] {
    FIX_ADDR   = 3'd0,
    INC_ADDR   = 3'd1,
    DEC_ADDR   = 3'd2,
    RUN_1_ADDR = 3'd3
  } addr_mode_t;

  // Raw encoding 3 is treated as a plain write test.
  function automatic test_mode_t decode_mode(input logic [1:0] raw);
    return (raw == 2'd3) ? WR_ONLY : test_mode_t'(raw);
  endfunction

endpackage

// File: rtl/test_sequencer.sv
// Per-test FSM of the memory checker: walks address_block, issues Avalon-MM
// writes/reads of an address-derived pattern and counts read-back errors.
module test_sequencer
  import rtl_settings_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int TMO_W  = 10
) (
  input  logic                                      clk_i,
  input  logic                                      rst_i,
  input  logic                                      test_start_i,
  input  logic [CSR_SET_ADDR:CSR_TEST_PARAM][31:0]  test_param_i,
  output logic                                      test_start_o,
  output logic                                      next_addr_en_o,
  input  logic [ADDR_W-1:0]                         addr_i,
  output logic [ADDR_W-1:0]                         amm_address_o,
  output logic                                      amm_write_o,
  output logic                                      amm_read_o,
  output logic [DATA_W-1:0]                         amm_writedata_o,
  input  logic                                      amm_waitrequest_i,
  input  logic                                      amm_readdatavalid_i,
  input  logic [DATA_W-1:0]                         amm_readdata_i,
  output logic                                      busy_o,
  output logic                                      done_o,
  output logic [31:0]                               err_cnt_o,
  output logic [ADDR_W-1:0]                         first_err_addr_o,
  output logic                                      timeout_o
);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_WR, S_RD, S_RD_WAIT, S_NEXT, S_DONE
  } state_t;

  state_t            state;
  test_mode_t        mode_q;
  logic [7:0]        pat_q;
  logic [10:0]       remaining;
  logic [TMO_W-1:0]  tmo_cnt;
  logic [31:0]       param;
  logic              rd_mismatch;
  logic              rd_timeout;
  logic              err_hit;

  function automatic logic [DATA_W-1:0] pattern_word(input logic [7:0] p,
                                                     input logic [ADDR_W-1:0] a);
    return {(DATA_W/8){p}} ^ DATA_W'(a);
  endfunction

  assign param = test_param_i[CSR_TEST_PARAM];

  // Address mode and base address belong to address_block.
  logic unused_param_bits;
  assign unused_param_bits = ^{test_param_i[CSR_SET_ADDR], param[31:PAT_MSB+1],
                               param[AMODE_MSB:AMODE_LSB]};

  assign test_start_o   = (state == S_IDLE) && test_start_i;
  assign next_addr_en_o = (state == S_NEXT) && (remaining != '0);

  assign rd_mismatch = amm_readdatavalid_i &&
                       (amm_readdata_i != pattern_word(pat_q, amm_address_o));
  assign rd_timeout  = !amm_readdatavalid_i && (tmo_cnt == '1);
  assign err_hit     = (state == S_RD_WAIT) && (rd_mismatch || rd_timeout);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state            <= S_IDLE;
      mode_q           <= WR_ONLY;
      pat_q            <= '0;
      remaining        <= '0;
      tmo_cnt          <= '0;
      amm_address_o    <= '0;
      amm_write_o      <= 1'b0;
      amm_read_o       <= 1'b0;
      amm_writedata_o  <= '0;
      busy_o           <= 1'b0;
      done_o           <= 1'b0;
      err_cnt_o        <= '0;
      first_err_addr_o <= '0;
      timeout_o        <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (test_start_i) begin
            err_cnt_o        <= '0;
            first_err_addr_o <= '0;
            timeout_o        <= 1'b0;
            done_o           <= 1'b0;
            busy_o           <= 1'b1;
            remaining        <= param[CNT_MSB:CNT_LSB];
            mode_q           <= decode_mode(param[TMODE_MSB:TMODE_LSB]);
            pat_q            <= param[PAT_MSB:PAT_LSB];
            state            <= S_LOAD;
          end
        end
        S_LOAD: begin
          amm_address_o <= addr_i;
          if (mode_q == RD_ONLY) begin
            amm_read_o <= 1'b1;
            state      <= S_RD;
          end else begin
            amm_write_o     <= 1'b1;
            amm_writedata_o <= pattern_word(pat_q, addr_i);
            state           <= S_WR;
          end
        end
        S_WR: begin
          if (!amm_waitrequest_i) begin
            amm_write_o <= 1'b0;
            if (mode_q == WR_RD) begin
              // Read-back reuses the address just written.
              amm_read_o <= 1'b1;
              state      <= S_RD;
            end else begin
              state <= S_NEXT;
            end
          end
        end
        S_RD: begin
          if (!amm_waitrequest_i) begin
            amm_read_o <= 1'b0;
            tmo_cnt    <= '0;
            state      <= S_RD_WAIT;
          end
        end
        S_RD_WAIT: begin
          if (amm_readdatavalid_i) begin
            state <= S_NEXT;
          end else if (rd_timeout) begin
            timeout_o <= 1'b1;
            state     <= S_NEXT;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        S_NEXT: begin
          if (remaining == '0) begin
            state <= S_DONE;
          end else begin
            remaining <= remaining - 1'b1;
            state     <= S_LOAD;
          end
        end
        S_DONE: begin
          done_o <= 1'b1;
          busy_o <= 1'b0;
          state  <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase

      if (err_hit) begin
        if (err_cnt_o == '0) first_err_addr_o <= amm_address_o;
        if (err_cnt_o != '1) err_cnt_o <= err_cnt_o + 1'b1;
      end
    end
  end

  a_strobe_excl: assert property (@(posedge clk_i) disable iff (rst_i)
    !(amm_write_o && amm_read_o));

  a_hold_under_wait: assert property (@(posedge clk_i) disable iff (rst_i)
    (amm_write_o || amm_read_o) && amm_waitrequest_i |=>
      $stable(amm_address_o) && $stable(amm_writedata_o));

endmodule

// File: tb/tb_test_sequencer.sv
// Scoreboard bench for test_sequencer: models address_block and an Avalon slave,
// queues the expected transaction stream per test and checks counters at done.
module tb_test_sequencer;
  import rtl_settings_pkg::*;

  localparam int DATA_W = 32;
  localparam int TMO_W  = 4;
  localparam int RD_LAT = 3;

  logic                                     clk_i = 1'b0;
  logic                                     rst_i = 1'b1;
  logic                                     test_start_i = 1'b0;
  logic [CSR_SET_ADDR:CSR_TEST_PARAM][31:0] test_param_i = '0;
  logic                                     test_start_o;
  logic                                     next_addr_en_o;
  logic [ADDR_W-1:0]                        addr_i;
  logic [ADDR_W-1:0]                        amm_address_o;
  logic                                     amm_write_o;
  logic                                     amm_read_o;
  logic [DATA_W-1:0]                        amm_writedata_o;
  logic                                     amm_waitrequest_i = 1'b0;
  logic                                     amm_readdatavalid_i = 1'b0;
  logic [DATA_W-1:0]                        amm_readdata_i = '0;
  logic                                     busy_o;
  logic                                     done_o;
  logic [31:0]                              err_cnt_o;
  logic [ADDR_W-1:0]                        first_err_addr_o;
  logic                                     timeout_o;

  always #5 clk_i = ~clk_i;

  test_sequencer #(.DATA_W(DATA_W), .TMO_W(TMO_W)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .test_start_i(test_start_i), .test_param_i(test_param_i),
    .test_start_o(test_start_o), .next_addr_en_o(next_addr_en_o), .addr_i(addr_i),
    .amm_address_o(amm_address_o), .amm_write_o(amm_write_o), .amm_read_o(amm_read_o),
    .amm_writedata_o(amm_writedata_o), .amm_waitrequest_i(amm_waitrequest_i),
    .amm_readdatavalid_i(amm_readdatavalid_i), .amm_readdata_i(amm_readdata_i),
    .busy_o(busy_o), .done_o(done_o), .err_cnt_o(err_cnt_o),
    .first_err_addr_o(first_err_addr_o), .timeout_o(timeout_o)
  );

  typedef struct packed {
    logic              wr;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } txn_t;

  txn_t              sb_q[$];
  logic [DATA_W-1:0] mem [logic [ADDR_W-1:0]];
  int                n_chk = 0;
  int                n_pass = 0;
  int                next_cnt;
  bit                rand_wait = 0;
  bit                no_rsp = 0;
  bit                corrupt_en = 0;
  logic [ADDR_W-1:0] corrupt_addr = '0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  function automatic logic [DATA_W-1:0] pat(input logic [7:0] p, input logic [ADDR_W-1:0] a);
    logic [DATA_W-1:0] w;
    w = {p, p, p, p};
    return w ^ {{(DATA_W-ADDR_W){1'b0}}, a};
  endfunction

  function automatic logic [ADDR_W-1:0] start_addr(input addr_mode_t m, input logic [ADDR_W-1:0] s);
    return (m == RUN_1_ADDR) ? ADDR_W'(1) : s;
  endfunction

  function automatic logic [ADDR_W-1:0] step_addr(input addr_mode_t m, input logic [ADDR_W-1:0] a);
    case (m)
      INC_ADDR:   return a + 1'b1;
      DEC_ADDR:   return a - 1'b1;
      RUN_1_ADDR: return {a[ADDR_W-2:0], a[ADDR_W-1]};
      default:    return a;
    endcase
  endfunction

  // address_block model
  always @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      addr_i   <= '0;
      next_cnt <= 0;
    end else if (test_start_o) begin
      addr_i   <= start_addr(addr_mode_t'(test_param_i[CSR_TEST_PARAM][AMODE_MSB:AMODE_LSB]),
                             test_param_i[CSR_SET_ADDR][ADDR_W-1:0]);
      next_cnt <= 0;
    end else if (next_addr_en_o) begin
      addr_i   <= step_addr(addr_mode_t'(test_param_i[CSR_TEST_PARAM][AMODE_MSB:AMODE_LSB]), addr_i);
      next_cnt <= next_cnt + 1;
    end
  end

  // Avalon slave: decisions made on the falling edge for the next rising edge
  initial begin
    bit                rd_pend = 0;
    int                rd_cnt = 0;
    logic [ADDR_W-1:0] rd_addr = '0;
    bit                prev_hold = 0;
    logic [ADDR_W-1:0] prev_addr = '0;
    logic [DATA_W-1:0] prev_data = '0;
    bit                prev_wr = 0;
    txn_t              t;
    forever begin
      @(negedge clk_i);
      if (rst_i) begin
        rd_pend = 0; prev_hold = 0;
        amm_waitrequest_i = 1'b0; amm_readdatavalid_i = 1'b0;
        continue;
      end
      if (amm_write_o || amm_read_o)
        chk("strobe_excl", {63'b0, amm_write_o & amm_read_o}, 64'd0);
      if (prev_hold) begin
        chk("addr_hold", 64'(amm_address_o), 64'(prev_addr));
        if (prev_wr) chk("wdata_hold", 64'(amm_writedata_o), 64'(prev_data));
      end
      amm_readdatavalid_i = 1'b0;
      if (rd_pend) begin
        if (rd_cnt == 0) begin
          rd_pend = 0;
          if (!no_rsp) begin
            amm_readdata_i = mem.exists(rd_addr) ? mem[rd_addr] : '0;
            if (corrupt_en && rd_addr == corrupt_addr) amm_readdata_i ^= 32'h1;
            amm_readdatavalid_i = 1'b1;
          end
        end else begin
          rd_cnt--;
        end
      end
      amm_waitrequest_i = rand_wait ? 1'($urandom_range(0, 1)) : 1'b0;
      if ((amm_write_o || amm_read_o) && !amm_waitrequest_i) begin
        if (sb_q.size() == 0) begin
          chk("sb_extra_txn", 64'd1, 64'd0);
        end else begin
          t = sb_q.pop_front();
          chk("sb_kind", {63'b0, amm_write_o}, {63'b0, t.wr});
          chk("sb_addr", 64'(amm_address_o), 64'(t.addr));
          if (amm_write_o) begin
            chk("sb_wdata", 64'(amm_writedata_o), 64'(t.data));
            mem[amm_address_o] = amm_writedata_o;
          end
        end
        if (amm_read_o) begin
          rd_pend = 1; rd_cnt = RD_LAT - 1; rd_addr = amm_address_o;
        end
      end
      prev_hold = (amm_write_o || amm_read_o) && amm_waitrequest_i;
      prev_addr = amm_address_o;
      prev_data = amm_writedata_o;
      prev_wr   = amm_write_o;
    end
  end

  task automatic start_test(input logic [1:0] tmode, input addr_mode_t am,
                            input logic [ADDR_W-1:0] set, input int nm1, input logic [7:0] p);
    logic [ADDR_W-1:0] a;
    txn_t t;
    test_param_i = '0;
    test_param_i[CSR_TEST_PARAM][CNT_MSB:CNT_LSB]     = 11'(nm1);
    test_param_i[CSR_TEST_PARAM][AMODE_MSB:AMODE_LSB] = am;
    test_param_i[CSR_TEST_PARAM][TMODE_MSB:TMODE_LSB] = tmode;
    test_param_i[CSR_TEST_PARAM][PAT_MSB:PAT_LSB]     = p;
    test_param_i[CSR_SET_ADDR] = 32'(set);
    a = start_addr(am, set);
    for (int i = 0; i <= nm1; i++) begin
      if (tmode != 2'd1) begin
        t.wr = 1'b1; t.addr = a; t.data = pat(p, a); sb_q.push_back(t);
      end
      if (tmode == 2'd1 || tmode == 2'd2) begin
        t.wr = 1'b0; t.addr = a; t.data = '0; sb_q.push_back(t);
      end
      a = step_addr(am, a);
    end
    @(negedge clk_i) test_start_i = 1'b1;
    @(negedge clk_i) test_start_i = 1'b0;
    chk("busy_running", {63'b0, busy_o}, 64'd1);
  endtask

  task automatic wait_done(input int budget, input int nm1);
    for (int c = 0; c < budget && !done_o; c++) @(negedge clk_i);
    chk("done_seen", {63'b0, done_o}, 64'd1);
    chk("busy_at_done", {63'b0, busy_o}, 64'd0);
    chk("sb_empty", 64'(sb_q.size()), 64'd0);
    chk("next_pulses", 64'(next_cnt), 64'(nm1));
    sb_q.delete();
  endtask

  task automatic preload(input logic [7:0] p, input int n);
    for (int i = 0; i < n; i++) mem[ADDR_W'(i)] = pat(p, ADDR_W'(i));
  endtask

  initial begin
    repeat (3) @(negedge clk_i);
    #1;
    chk("rst_busy", {63'b0, busy_o}, 64'd0);
    chk("rst_done", {63'b0, done_o}, 64'd0);
    chk("rst_write", {63'b0, amm_write_o}, 64'd0);
    chk("rst_read", {63'b0, amm_read_o}, 64'd0);
    chk("rst_err", 64'(err_cnt_o), 64'd0);
    @(negedge clk_i) rst_i = 1'b0;

    // 1: write only, incrementing from 0x10
    start_test(2'd0, INC_ADDR, 16'h0010, 3, 8'hA5);
    wait_done(200, 3);
    chk("t1_err", 64'(err_cnt_o), 64'd0);
    chk("t1_mem13", 64'(mem[16'h0013]), 64'hA5A5A5B6);

    // 2: write/read-back, fixed address
    start_test(2'd2, FIX_ADDR, 16'h0020, 1, 8'h5A);
    wait_done(200, 1);
    chk("t2_err", 64'(err_cnt_o), 64'd0);
    chk("t2_tmo", {63'b0, timeout_o}, 64'd0);

    // 3: read only with a corrupted word at 5
    preload(8'h3C, 8);
    corrupt_en = 1; corrupt_addr = 16'd5;
    start_test(2'd1, INC_ADDR, 16'h0000, 7, 8'h3C);
    wait_done(400, 7);
    chk("t3_err", 64'(err_cnt_o), 64'd1);
    chk("t3_first", 64'(first_err_addr_o), 64'd5);
    corrupt_en = 0;

    // 4: slave never answers
    no_rsp = 1;
    start_test(2'd1, FIX_ADDR, 16'h0030, 1, 8'h11);
    wait_done(200, 1);
    chk("t4_tmo", {63'b0, timeout_o}, 64'd1);
    chk("t4_err", 64'(err_cnt_o), 64'd2);
    chk("t4_first", 64'(first_err_addr_o), 64'h30);
    no_rsp = 0;

    // 5: random waitrequest, walking-one addresses
    rand_wait = 1;
    start_test(2'd2, RUN_1_ADDR, 16'h0000, 15, 8'hC3);
    wait_done(2000, 15);
    chk("t5_err", 64'(err_cnt_o), 64'd0);
    rand_wait = 0;

    // 6a: reset while waiting for read data
    no_rsp = 1;
    start_test(2'd1, FIX_ADDR, 16'h0040, 3, 8'h77);
    for (int c = 0; c < 100 && err_cnt_o == 0; c++) @(negedge clk_i);
    chk("t6_pre_err", 64'(err_cnt_o), 64'd1);
    repeat (5) @(negedge clk_i);
    rst_i = 1'b1;
    #1;
    chk("t6_busy", {63'b0, busy_o}, 64'd0);
    chk("t6_read", {63'b0, amm_read_o}, 64'd0);
    chk("t6_err", 64'(err_cnt_o), 64'd0);
    chk("t6_tmo", {63'b0, timeout_o}, 64'd0);
    chk("t6_first", 64'(first_err_addr_o), 64'd0);
    chk("t6_addr", 64'(amm_address_o), 64'd0);
    sb_q.delete();
    no_rsp = 0;
    @(negedge clk_i) rst_i = 1'b0;

    // 6b: a start while busy is ignored
    preload(8'h96, 8);
    corrupt_en = 1; corrupt_addr = 16'd5;
    start_test(2'd1, INC_ADDR, 16'h0000, 7, 8'h96);
    repeat (10) @(negedge clk_i);
    test_start_i = 1'b1;
    @(negedge clk_i) test_start_i = 1'b0;
    wait_done(400, 7);
    chk("t6b_err", 64'(err_cnt_o), 64'd1);
    chk("t6b_first", 64'(first_err_addr_o), 64'd5);
    repeat (5) @(negedge clk_i);
    chk("t6b_done_held", {63'b0, done_o}, 64'd1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
